// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential signed divider:
//   - DIV_WIDTH : default operand/result width (two's complement)
//   - div_state_e : controller states (IDLE, CALC, DONE)
//   - DIV_MIN   : most negative operand value (1 followed by zeros)
//   - twos_neg  : two's-complement negate (invert + 1) at DIV_WIDTH bits
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    // Two's-complement negate; the most negative value maps onto itself,
    // which is exactly the unsigned magnitude 2^(DIV_WIDTH-1).
    function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] v);
        return ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration on unsigned magnitudes.
// Ports:
//   rem_in  [WIDTH:0]   partial remainder before this step
//   bit_in              next dividend bit (MSB first) shifted into the remainder
//   divisor [WIDTH-1:0] divisor magnitude
//   rem_out [WIDTH:0]   partial remainder after this step
//   q_bit               quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   sub_b_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH+1:0] carry_s;

    assign shifted_s  = {rem_in[WIDTH-1:0], bit_in};
    // Subtraction as addition of the inverted divisor with carry-in 1
    assign sub_b_s    = ~{1'b0, divisor};
    assign carry_s[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i <= WIDTH; i++) begin : g_fa
            assign diff_s[i]      = shifted_s[i] ^ sub_b_s[i] ^ carry_s[i];
            assign carry_s[i+1]   = (shifted_s[i] & sub_b_s[i])
                                  | (carry_s[i] & (shifted_s[i] ^ sub_b_s[i]));
        end
    endgenerate

    // Carry-out high means no borrow. A set bit shifted out of rem_in means the
    // true shifted value already exceeds any divisor, so the subtract succeeds
    // and the modular difference is the exact remainder.
    assign q_bit   = carry_s[WIDTH+1] | rem_in[WIDTH];
    assign rem_out = q_bit ? diff_s : shifted_s;

endmodule

// File: rtl/signed_div5_seq.sv
// -----------------------------------------------------------------------------
// signed_div5_seq
// Sequential signed two's-complement divider, one restoring step per clock.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-high reset
//   start     request, sampled in IDLE or DONE only
//   A, B      signed dividend / divisor, captured on the accepted start edge
//   busy      high while iterating
//   done      one-cycle pulse when a result has been registered
//   Quot, Rem signed quotient / remainder (truncating division), held
//   DivByZero result flag: divisor was zero (Quot = all ones, Rem = A)
//   OF_div    result flag: most-negative / -1 overflow
// Build option:
//   SIGNED_DIV5_FAST_EXIT_EN - when A == 0 or B == 0 the result is ready one
//   cycle after the accept edge and busy stays low.
// -----------------------------------------------------------------------------
module signed_div5_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             DivByZero,
    output logic             OF_div
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;        // original operands, for signs and flags
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0] dvs_q, dvs_d;    // divisor magnitude
    logic [WIDTH:0]   prem_q, prem_d;  // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;    // quotient magnitude bits so far
    logic             fast_q, fast_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             of_q, of_d;

    logic [WIDTH:0]   step_rem_s;
    logic             step_q_s;
    logic             fast_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s;
    logic [WIDTH-1:0] fin_q_s, fin_r_s;
    logic [WIDTH-1:0] fix_quot_s, fix_rem_s;
    logic             fix_dbz_s, fix_of_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

`ifdef SIGNED_DIV5_FAST_EXIT_EN
    assign fast_s = (A == {WIDTH{1'b0}}) || (B == {WIDTH{1'b0}});
`else
    assign fast_s = 1'b0;
`endif

    // Operand magnitudes; |DIV_MIN| is representable as an unsigned value
    always_comb begin
        if (A[WIDTH-1]) begin
            mag_a_s = twos_neg(A);
        end else begin
            mag_a_s = A;
        end
        if (B[WIDTH-1]) begin
            mag_b_s = twos_neg(B);
        end else begin
            mag_b_s = B;
        end
    end

    // Final magnitudes after the last step, then sign fix-up and flag overrides
    always_comb begin
        fin_q_s    = {quo_q[WIDTH-2:0], step_q_s};
        fin_r_s    = step_rem_s[WIDTH-1:0];
        fix_quot_s = fin_q_s;
        fix_rem_s  = fin_r_s;
        fix_dbz_s  = 1'b0;
        fix_of_s   = 1'b0;
        if (b_q == {WIDTH{1'b0}}) begin
            fix_quot_s = {WIDTH{1'b1}};
            fix_rem_s  = a_q;
            fix_dbz_s  = 1'b1;
        end else if ((a_q == DIV_MIN) && (b_q == {WIDTH{1'b1}})) begin
            fix_quot_s = DIV_MIN;
            fix_rem_s  = {WIDTH{1'b0}};
            fix_of_s   = 1'b1;
        end else begin
            // Truncation toward zero: negate quotient on sign mismatch,
            // remainder follows the dividend's sign.
            if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) begin
                fix_quot_s = twos_neg(fin_q_s);
            end else begin
                fix_quot_s = fin_q_s;
            end
            if (a_q[WIDTH-1]) begin
                fix_rem_s = twos_neg(fin_r_s);
            end else begin
                fix_rem_s = fin_r_s;
            end
        end
    end

    // Controller next-state, iteration datapath and result loading
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        fast_d  = fast_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        of_d    = of_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CALC;
                    a_d     = A;
                    b_d     = B;
                    dvd_d   = mag_a_s;
                    dvs_d   = mag_b_s;
                    prem_d  = {(WIDTH+1){1'b0}};
                    quo_d   = {WIDTH{1'b0}};
                    fast_d  = fast_s;
                    // A trivial operand runs a single hidden step: with a zero
                    // dividend that step yields 0/0, a zero divisor is
                    // overridden by the fix-up anyway.
                    if (fast_s) begin
                        cnt_d = CNT_LAST;
                    end else begin
                        cnt_d = CNT_ZERO;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                prem_d = step_rem_s;
                quo_d  = {quo_q[WIDTH-2:0], step_q_s};
                dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    quot_d  = fix_quot_s;
                    rem_d   = fix_rem_s;
                    dbz_d   = fix_dbz_s;
                    of_d    = fix_of_s;
                end else begin
                    state_d = CALC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CALC) && !fast_d;
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            dvd_q   <= {WIDTH{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            prem_q  <= {(WIDTH+1){1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            fast_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            fast_q  <= fast_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            of_q    <= of_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Quot      = quot_q;
    assign Rem       = rem_q;
    assign DivByZero = dbz_q;
    assign OF_div    = of_q;

endmodule

// File: tb/tb_signed_div5_seq.sv
// -----------------------------------------------------------------------------
// tb_signed_div5_seq
// Self-checking bench: directed vector table, control corner sequences,
// exhaustive operand sweep and random operands against a plain-arithmetic
// reference model. Honours SIGNED_DIV5_FAST_EXIT_EN for expected latency.
// -----------------------------------------------------------------------------
module tb_signed_div5_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] A;
    logic [4:0] B;
    logic       busy;
    logic       done;
    logic [4:0] Quot;
    logic [4:0] Rem;
    logic       DivByZero;
    logic       OF_div;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] q;
        logic [4:0] r;
        logic       dz;
        logic       ov;
    } vec_t;

    vec_t vecs [11];

    signed_div5_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .Quot      (Quot),
        .Rem       (Rem),
        .DivByZero (DivByZero),
        .OF_div    (OF_div)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: truncating signed division from plain integer arithmetic
    task automatic ref_div(input logic [4:0] a, input logic [4:0] b,
                           output logic [4:0] q, output logic [4:0] r,
                           output logic dz, output logic ov);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        dz = 1'b0;
        ov = 1'b0;
        if (ib == 0) begin
            q  = 5'b11111;
            r  = a;
            dz = 1'b1;
        end else if (ia == -16 && ib == -1) begin
            q  = 5'b10000;
            r  = 5'b00000;
            ov = 1'b1;
        end else begin
            q = 5'(ia / ib);
            r = 5'(ia % ib);
        end
    endtask

    function automatic int exp_lat(input logic [4:0] a, input logic [4:0] b);
`ifdef SIGNED_DIV5_FAST_EXIT_EN
        if (a == 5'd0 || b == 5'd0) return 1;
`endif
        return 5;
    endfunction

    function automatic logic [31:0] pack(input logic [4:0] q, input logic [4:0] r,
                                         input logic dz, input logic ov);
        return {20'd0, dz, ov, q, r};
    endfunction

    // One division: returns cycles from accept edge to done and busy cycles seen
    task automatic run_div(input logic [4:0] a, input logic [4:0] b,
                           output int lat, output int busy_cycles);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        lat         = 0;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        logic [4:0] eq, er;
        logic edz, eov;
        logic seen_done;

        vecs[0]  = '{5'd7,     5'd2,     5'd3,     5'd1,     1'b0, 1'b0};
        vecs[1]  = '{5'b11001, 5'd2,     5'b11101, 5'b11111, 1'b0, 1'b0};
        vecs[2]  = '{5'd7,     5'b11110, 5'b11101, 5'd1,     1'b0, 1'b0};
        vecs[3]  = '{5'b10000, 5'b11111, 5'b10000, 5'd0,     1'b0, 1'b1};
        vecs[4]  = '{5'd5,     5'd0,     5'b11111, 5'b00101, 1'b1, 1'b0};
        vecs[5]  = '{5'd0,     5'd3,     5'd0,     5'd0,     1'b0, 1'b0};
        vecs[6]  = '{5'b10000, 5'd1,     5'b10000, 5'd0,     1'b0, 1'b0};
        vecs[7]  = '{5'd15,    5'b10000, 5'd0,     5'd15,    1'b0, 1'b0};
        vecs[8]  = '{5'b10000, 5'b10000, 5'd1,     5'd0,     1'b0, 1'b0};
        vecs[9]  = '{5'b11111, 5'd2,     5'd0,     5'b11111, 1'b0, 1'b0};
        vecs[10] = '{5'd0,     5'd0,     5'b11111, 5'd0,     1'b1, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        A     = 5'd0;
        B     = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, DivByZero, OF_div, Quot, Rem}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i].a, vecs[i].b, lat, bc);
            check($sformatf("vec%0d_result", i), pack(Quot, Rem, DivByZero, OF_div),
                  pack(vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov));
            check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].a, vecs[i].b));
            check($sformatf("vec%0d_busy", i), bc, (exp_lat(vecs[i].a, vecs[i].b) == 1) ? 0 : 5);
        end

        // done lasts exactly one cycle when start stays low
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);

        // start mid-CALC with new operands is ignored
        @(negedge clk);
        A     = 5'd7;
        B     = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!done && lat < 20) begin
            if (lat == 2) begin
                A     = 5'd1;
                B     = 5'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("midcalc_latency", lat, 5);
        check("midcalc_result", pack(Quot, Rem, DivByZero, OF_div), pack(5'd3, 5'd1, 1'b0, 1'b0));

        // start held in DONE -> next division accepted with no idle cycle
        A     = 5'b11001;
        B     = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_accept", {busy, done}, 2'b10);
        check("b2b_held_quot", Quot, 5'd3);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_latency", lat, 5);
        check("b2b_result", pack(Quot, Rem, DivByZero, OF_div), pack(5'b11101, 5'b11111, 1'b0, 1'b0));

        // reset during CALC iteration 2 aborts without done
        @(negedge clk);
        A     = 5'd7;
        B     = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_outputs", {busy, done, DivByZero, OF_div, Quot, Rem}, 32'd0);
        seen_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | done;
        end
        check("abort_no_done", seen_done, 1'b0);

        // Exhaustive sweep against the reference model
        for (int ia = 0; ia < 32; ia++) begin
            for (int ib = 0; ib < 32; ib++) begin
                run_div(5'(ia), 5'(ib), lat, bc);
                ref_div(5'(ia), 5'(ib), eq, er, edz, eov);
                check($sformatf("sweep_%0d_%0d", ia, ib), pack(Quot, Rem, DivByZero, OF_div),
                      pack(eq, er, edz, eov));
                check($sformatf("sweep_lat_%0d_%0d", ia, ib), lat, exp_lat(5'(ia), 5'(ib)));
            end
        end

        // Random operands with random idle gaps
        for (int n = 0; n < 100; n++) begin
            logic [4:0] ra, rb;
            ra = 5'($urandom_range(31, 0));
            rb = 5'($urandom_range(31, 0));
            repeat ($urandom_range(2, 0)) @(posedge clk);
            run_div(ra, rb, lat, bc);
            ref_div(ra, rb, eq, er, edz, eov);
            check($sformatf("rand_%0d", n), pack(Quot, Rem, DivByZero, OF_div), pack(eq, er, edz, eov));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/signed_div5_seq.md
Name: signed_div5_seq

Overview:
- Sequential signed two's-complement divider: 5-bit dividend A, 5-bit divisor B, producing quotient and remainder.
- Complements the combinational 5-bit adder/subtractor/comparator datapath by running the inverse operation: one restoring subtract-and-compare step per clock.
- Start/busy/done handshake toward the controlling logic; one division in flight at a time.

Parameters:
- WIDTH, 5, operand/result width in bits (two's complement); all rules below are stated for WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- A  input  WIDTH  signed dividend; captured on the accepted start edge
- B  input  WIDTH  signed divisor; captured on the accepted start edge
- busy  output  1  high while in CALC
- done  output  1  high for exactly one cycle while in DONE
- Quot  output  WIDTH  signed quotient; held until the next result is registered
- Rem  output  WIDTH  signed remainder; held likewise
- DivByZero  output  1  result flag: divisor was 0
- OF_div  output  1  result flag: quotient unrepresentable (A = -2^(WIDTH-1), B = -1)

Behaviour:
- Reset: state IDLE; busy, done, Quot, Rem, DivByZero, OF_div, counter and internal registers all 0. Reset during CALC or DONE aborts the operation; no done is produced.
- States:
  - IDLE: start=1 -> CALC.
  - CALC: counts iterations 0..WIDTH-1; after iteration WIDTH-1 -> DONE.
  - DONE: start=1 -> CALC (back-to-back accepted); otherwise -> IDLE.
- Accept edge: capture sign(A) and sign(B); store |A| and |B| as unsigned WIDTH-bit magnitudes (|-16| = 5'b10000 fits unsigned). Clear the partial remainder (WIDTH+1 bits) and counter.
- start during CALC is ignored; no queuing.
- Each CALC edge performs one restoring step:
  - Shift {remainder, dividend MSB} left.
  - Trial-subtract |B|. If the result is >= 0, keep it and shift in quotient bit 1; else restore and shift in 0.
- Latency: start accepted at edge k; results registered and done=1 after edge k+WIDTH (5 cycles at default). done falls after the next edge.
- Sign fix-up applied at the DONE-entry edge:
  - Quotient negated when sign(A) != sign(B); truncation toward zero.
  - Remainder takes the sign of A. A = Quot*B + Rem holds for every non-flagged case.
- Divide by zero: full latency; Quot = all ones, Rem = A, DivByZero=1, OF_div=0.
- Overflow (A = 5'b10000, B = 5'b11111): Quot = 5'b10000, Rem = 0, OF_div=1.
- Flags reflect only the most recent result and are cleared on the next DONE entry if not applicable.
- Outputs change only on a DONE-entry edge or on reset.

Optional Feature:
- Macro: SIGNED_DIV5_FAST_EXIT_EN.
- Defined: if B == 0 or A == 0 on the accepted start edge, skip CALC and go IDLE/DONE -> DONE directly. done is high one cycle after the accept edge. Results are the same as the full-latency path (A=0 gives Quot=0, Rem=0). busy stays 0.
- Undefined: every operation takes exactly WIDTH cycles.

Decomposition:
- Package div_pkg: state enum (IDLE, CALC, DONE), localparam WIDTH default, DIV_MIN constant (1 followed by zeros), helper function for two's-complement negate (invert + 1).
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, shifted-in bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
  - The trial subtract is built from the existing full-adder chain with an inverted divisor and carry-in 1.
- Top holds the FSM, counter, operand registers and sign fix-up.

Test Plan:
- A=7, B=2, start one cycle -> busy=1 for 5 cycles; done=1 on cycle 5; Quot=3, Rem=1, flags 0.
- A=-7 (5'b11001), B=2 -> Quot=5'b11101 (-3), Rem=5'b11111 (-1).
- A=7, B=-2 -> Quot=-3, Rem=1.
- A=-16, B=-1 -> Quot=5'b10000, Rem=0, OF_div=1.
- A=5, B=0 -> Quot=5'b11111, Rem=5'b00101, DivByZero=1.
  - Without the macro: done at cycle 5.
  - With SIGNED_DIV5_FAST_EXIT_EN: done at cycle 1.
- Control corner cases:
  - start pulsed mid-CALC with new operands -> ignored; first result is unchanged.
  - start high in DONE -> next division accepted with no idle cycle.
  - reset asserted at CALC iteration 2 -> IDLE next edge, all outputs 0, no done.
- Exhaustive sweep: all 1024 A/B pairs vs. a reference model (truncating division) -> zero mismatches.
